cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 101 ++++++++++
 tb/tb_cdb_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// ============================================================================
// Module   : cdb_arbiter
// Brief    : Round-robin arbiter that picks one functional-unit result per
//            cycle and registers it onto the common data bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 5,
    parameter int DATA_W  = 32,
    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [PTR_W-1:0]          rr_ptr
);

    logic               cdb_valid_q;
    logic [TAG_W-1:0]   cdb_tag_q;
    logic [DATA_W-1:0]  cdb_data_q;
    logic [PTR_W-1:0]   rr_ptr_q;
    logic [PTR_W-1:0]   rr_ptr_d;

    logic               w_found;
    logic [PTR_W-1:0]   w_win;
    logic [PTR_W-1:0]   w_cand;
    logic [NUM_REQ-1:0] w_ready;
    logic [TAG_W-1:0]   w_tag;
    logic [DATA_W-1:0]  w_data;

    // (base + off) modulo NUM_REQ, for off in 0..NUM_REQ
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                   input int              off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return s[PTR_W-1:0];
    endfunction

    // Scan from the priority pointer; first valid requester wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = wrap_add(rr_ptr_q, k);
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (w_found && !rst) begin
            w_ready[w_win] = 1'b1;
        end
    end

    assign w_tag    = req_tag[w_win*TAG_W +: TAG_W];
    assign w_data   = req_data[w_win*DATA_W +: DATA_W];
    assign rr_ptr_d = wrap_add(w_win, 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            rr_ptr_q    <= '0;
        end else if (|w_ready) begin
            cdb_valid_q <= 1'b1;
            cdb_tag_q   <= w_tag;
            cdb_data_q  <= w_data;
            rr_ptr_q    <= rr_ptr_d;
        end else begin
            // Idle cycle: tag/data keep their last broadcast values.
            cdb_valid_q <= 1'b0;
        end
    end

    assign req_ready = w_ready;
    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;
    assign rr_ptr    = rr_ptr_q;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ============================================================================
// Module   : tb_cdb_arbiter
// Brief    : Directed plus randomized bench for cdb_arbiter with a behavioural
//            round-robin reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int TW = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*TW-1:0] req_tag;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            cdb_valid;
    logic [TW-1:0]   cdb_tag;
    logic [DW-1:0]   cdb_data;
    logic [1:0]      rr_ptr;

    always #5 clk = ~clk;

    cdb_arbiter #(.NUM_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .rr_ptr    (rr_ptr)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Requester-side stimulus state
    logic [N-1:0]  vl;
    logic [TW-1:0] tg [N];
    logic [DW-1:0] dt [N];

    // Reference model: what the bus registers should hold after the last edge
    bit            m_known = 1'b0;
    bit            m_valid;
    logic [TW-1:0] m_tag;
    logic [DW-1:0] m_data;
    int            m_ptr = 0;
    int            last_grant;

    task automatic chk(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check mid-low phase, advance model for the edge.
    task automatic cycle(input bit r);
        int           w;
        logic [N-1:0] eg;
        @(negedge clk);
        rst       = r;
        req_valid = vl;
        for (int i = 0; i < N; i++) begin
            req_tag[i*TW +: TW]  = tg[i];
            req_data[i*DW +: DW] = dt[i];
        end
        #1;
        w = -1;
        if (!r) begin
            for (int k = 0; k < N; k++) begin
                if (w < 0 && vl[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
        end
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        chk("req_ready", DW'(req_ready), DW'(eg));
        if (m_known) begin
            chk("cdb_valid", DW'(cdb_valid), DW'(m_valid));
            chk("cdb_tag", DW'(cdb_tag), DW'(m_tag));
            chk("cdb_data", cdb_data, m_data);
            chk("rr_ptr", DW'(rr_ptr), DW'(m_ptr));
        end
        last_grant = w;
        if (r) begin
            m_known = 1'b1;
            m_valid = 1'b0;
            m_tag   = '0;
            m_data  = '0;
            m_ptr   = 0;
        end else if (w >= 0) begin
            m_valid = 1'b1;
            m_tag   = tg[w];
            m_data  = dt[w];
            m_ptr   = (w + 1) % N;
        end else begin
            m_valid = 1'b0;
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_tag   = '0;
        req_data  = '0;
        vl        = '0;
        for (int i = 0; i < N; i++) begin
            tg[i] = '0;
            dt[i] = '0;
        end

        // Reset held 10 cycles with no requests
        repeat (10) cycle(1'b1);
        chk("rst_rr_ptr", DW'(rr_ptr), 32'd0);
        chk("rst_cdb_valid", DW'(cdb_valid), 32'd0);

        // Single request from requester 2
        vl = 4'b0100; tg[2] = 5'd7; dt[2] = 32'hDEADBEEF;
        cycle(1'b0);
        chk("single_ready", DW'(req_ready), 32'b0100);
        vl = '0;
        cycle(1'b0);
        chk("single_cdb_valid", DW'(cdb_valid), 32'd1);
        chk("single_cdb_tag", DW'(cdb_tag), 32'd7);
        chk("single_cdb_data", cdb_data, 32'hDEADBEEF);
        chk("single_rr_ptr", DW'(rr_ptr), 32'd3);
        cycle(1'b0);
        chk("single_bubble", DW'(cdb_valid), 32'd0);

        // Wrap-around from rr_ptr=3 with requesters 0 and 3 pending
        vl = 4'b1001; tg[0] = 5'd10; tg[3] = 5'd13; dt[0] = 32'h0A; dt[3] = 32'h0D;
        cycle(1'b0);
        chk("wrap_grant3", DW'(req_ready), 32'b1000);
        vl[3] = 1'b0;
        cycle(1'b0);
        chk("wrap_grant0", DW'(req_ready), 32'b0001);
        chk("wrap_rr_ptr", DW'(rr_ptr), 32'd0);
        vl = '0;
        cycle(1'b0);
        chk("wrap_cdb_tag", DW'(cdb_tag), 32'd10);

        // All four continuously valid: strict rotation
        cycle(1'b1);
        vl = 4'b1111;
        for (int i = 0; i < N; i++) begin
            tg[i] = TW'(i + 1);
            dt[i] = $urandom;
        end
        for (int j = 0; j < 6; j++) begin
            cycle(1'b0);
            chk("rot_grant", DW'(req_ready), DW'(1 << (j % N)));
            if (j > 0) chk("rot_tag", DW'(cdb_tag), DW'(((j - 1) % N) + 1));
            dt[last_grant] = $urandom;
        end
        vl = '0;
        cycle(1'b0);

        // Sole requester 1 streaming back-to-back
        vl = 4'b0010;
        for (int j = 0; j < 11; j++) begin
            if (j == 10) vl = '0;
            dt[1] = $urandom;
            cycle(1'b0);
            if (j > 0) chk("stream_valid", DW'(cdb_valid), 32'd1);
        end

        // Reset right after requester 1 is granted
        vl = 4'b0010; dt[1] = 32'h1234_5678;
        cycle(1'b0);
        cycle(1'b1);
        chk("midrst_ready", DW'(req_ready), 32'd0);
        cycle(1'b0);
        chk("midrst_cdb_valid", DW'(cdb_valid), 32'd0);
        chk("midrst_rr_ptr", DW'(rr_ptr), 32'd0);
        chk("midrst_regrant", DW'(req_ready), 32'b0010);

        // Randomized traffic; requesters hold their payload until granted
        vl = '0;
        for (int c = 0; c < 400; c++) begin
            cycle($urandom_range(0, 39) == 0);
            for (int i = 0; i < N; i++) begin
                if (vl[i]) begin
                    if (i == last_grant) begin
                        vl[i] = 1'($urandom_range(0, 1));
                        tg[i] = TW'($urandom);
                        dt[i] = $urandom;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    vl[i] = 1'b1;
                    tg[i] = TW'($urandom);
                    dt[i] = $urandom;
                end
            end
        end
        vl = '0;
        cycle(1'b0);
        cycle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
